// File: rtl/cache_pkg.sv
// Shared types and geometry for the two-way write-back data cache.
// Lines are one word wide; the address splits as {tag, set, byte offset}.
package cache_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int SETS       = 16;
    localparam int SET_BITS   = $clog2(SETS);
    localparam int TAG_BITS   = ADDR_WIDTH - SET_BITS - 2;

    typedef struct packed {
        logic                  valid;
        logic                  dirty;
        logic [TAG_BITS-1:0]   tag;
        logic [DATA_WIDTH-1:0] data;
    } cache_entry_t;

    typedef struct packed {
        cache_entry_t entry1;
        cache_entry_t entry0;
    } cache_set_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOOKUP    = 2'd1,
        WRITEBACK = 2'd2,
        REFILL    = 2'd3
    } cache_state_t;

    function automatic logic [ADDR_WIDTH-1:0] line_addr(input logic [TAG_BITS-1:0] tag,
                                                       input logic [SET_BITS-1:0] set);
        return {tag, set, 2'b00};
    endfunction

endpackage

// File: rtl/cache_if.sv
// CPU data port plus memory req/ack port of the cache.
// The controller takes the slave view; the CPU/memory environment takes the master view.
interface cache_if;
    import cache_pkg::*;

    logic                  cpu_req_valid;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic                  cpu_ready;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  hit;
    logic                  miss;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ack;

    modport master (
        output cpu_req_valid, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
        input  cpu_ready, cpu_rdata, hit, miss, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  cpu_req_valid, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
        output cpu_ready, cpu_rdata, hit, miss, mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/cache_way_select.sv
// Tag compare against both ways of one set, plus victim choice for a miss:
// first invalid way (way0 first), else the least-recently-used way.
module cache_way_select
    import cache_pkg::*;
(
    input  cache_set_t          set_i,
    input  logic [TAG_BITS-1:0] tag_i,
    input  logic                lru_i,
    output logic                hit0_o,
    output logic                hit1_o,
    output logic                victim_o,
    output logic                victim_dirty_o
);

    // Hit detection and victim selection for the addressed set.
    always_comb begin
        hit0_o = set_i.entry0.valid && (set_i.entry0.tag == tag_i);
        hit1_o = set_i.entry1.valid && (set_i.entry1.tag == tag_i);
        if (!set_i.entry0.valid) begin
            victim_o = 1'b0;
        end else if (!set_i.entry1.valid) begin
            victim_o = 1'b1;
        end else begin
            victim_o = lru_i;
        end
        if (victim_o) begin
            victim_dirty_o = set_i.entry1.valid && set_i.entry1.dirty;
        end else begin
            victim_dirty_o = set_i.entry0.valid && set_i.entry0.dirty;
        end
    end

endmodule

// File: rtl/cache_controller.sv
// Two-way set-associative write-back, write-allocate data cache with one-word lines.
// One request at a time: lookup, optional dirty writeback, refill, then a replayed lookup.
module cache_controller
    import cache_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    cache_if.slave bus
);

    cache_set_t            sets_q [SETS];
    logic [SETS-1:0]       lru_q;
    cache_state_t          state_q;
    logic [TAG_BITS-1:0]   req_tag_q;
    logic [SET_BITS-1:0]   req_set_q;
    logic                  req_we_q;
    logic [DATA_WIDTH-1:0] req_wdata_q;
    logic                  first_q;
    logic                  victim_q;

    logic                  cpu_ready_q;
    logic [DATA_WIDTH-1:0] cpu_rdata_q;
    logic                  hit_q;
    logic                  miss_q;
    logic                  mem_req_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;

    cache_set_t            cur_set_s;
    cache_entry_t          victim_entry_s;
    logic                  hit0_s;
    logic                  hit1_s;
    logic                  victim_s;
    logic                  victim_dirty_s;
    logic                  unused_addr_bits_s;

    assign cur_set_s          = sets_q[req_set_q];
    assign unused_addr_bits_s = ^bus.cpu_addr[1:0];

    cache_way_select u_way_select (
        .set_i          (cur_set_s),
        .tag_i          (req_tag_q),
        .lru_i          (lru_q[req_set_q]),
        .hit0_o         (hit0_s),
        .hit1_o         (hit1_s),
        .victim_o       (victim_s),
        .victim_dirty_o (victim_dirty_s)
    );

    // Entry that a miss would displace.
    always_comb begin
        if (victim_s) begin
            victim_entry_s = cur_set_s.entry1;
        end else begin
            victim_entry_s = cur_set_s.entry0;
        end
    end

    assign bus.cpu_ready = cpu_ready_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.hit       = hit_q;
    assign bus.miss      = miss_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    // Miss-handling FSM, cache arrays and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lru_q       <= '0;
            req_tag_q   <= '0;
            req_set_q   <= '0;
            req_we_q    <= 1'b0;
            req_wdata_q <= '0;
            first_q     <= 1'b0;
            victim_q    <= 1'b0;
            cpu_ready_q <= 1'b0;
            cpu_rdata_q <= '0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                sets_q[s].entry0.valid <= 1'b0;
                sets_q[s].entry0.dirty <= 1'b0;
                sets_q[s].entry1.valid <= 1'b0;
                sets_q[s].entry1.dirty <= 1'b0;
            end
        end else begin
            cpu_ready_q <= 1'b0;
            cpu_rdata_q <= '0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.cpu_req_valid) begin
                        req_tag_q   <= bus.cpu_addr[ADDR_WIDTH-1:SET_BITS+2];
                        req_set_q   <= bus.cpu_addr[SET_BITS+1:2];
                        req_we_q    <= bus.cpu_we;
                        req_wdata_q <= bus.cpu_wdata;
                        first_q     <= 1'b1;
                        state_q     <= LOOKUP;
                    end else begin
                        state_q     <= IDLE;
                    end
                end
                LOOKUP: begin
                    first_q <= 1'b0;
                    if (hit0_s || hit1_s) begin
                        cpu_ready_q        <= 1'b1;
                        hit_q              <= first_q;
                        lru_q[req_set_q]   <= hit0_s;
                        state_q            <= IDLE;
                        if (req_we_q) begin
                            if (hit1_s) begin
                                sets_q[req_set_q].entry1.data  <= req_wdata_q;
                                sets_q[req_set_q].entry1.dirty <= 1'b1;
                            end else begin
                                sets_q[req_set_q].entry0.data  <= req_wdata_q;
                                sets_q[req_set_q].entry0.dirty <= 1'b1;
                            end
                        end else begin
                            cpu_rdata_q <= hit1_s ? cur_set_s.entry1.data : cur_set_s.entry0.data;
                        end
                    end else begin
                        miss_q    <= first_q;
                        victim_q  <= victim_s;
                        mem_req_q <= 1'b1;
                        if (victim_dirty_s) begin
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= line_addr(victim_entry_s.tag, req_set_q);
                            mem_wdata_q <= victim_entry_s.data;
                            state_q     <= WRITEBACK;
                        end else begin
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= line_addr(req_tag_q, req_set_q);
                            mem_wdata_q <= '0;
                            state_q     <= REFILL;
                        end
                    end
                end
                WRITEBACK: begin
                    // Refill follows immediately, so mem_req stays high across the switch.
                    if (bus.mem_ack && mem_req_q) begin
                        if (victim_q) begin
                            sets_q[req_set_q].entry1.dirty <= 1'b0;
                        end else begin
                            sets_q[req_set_q].entry0.dirty <= 1'b0;
                        end
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= line_addr(req_tag_q, req_set_q);
                        mem_wdata_q <= '0;
                        state_q     <= REFILL;
                    end else begin
                        state_q     <= WRITEBACK;
                    end
                end
                REFILL: begin
                    if (bus.mem_ack && mem_req_q) begin
                        if (victim_q) begin
                            sets_q[req_set_q].entry1 <= '{valid: 1'b1, dirty: 1'b0,
                                                          tag: req_tag_q, data: bus.mem_rdata};
                        end else begin
                            sets_q[req_set_q].entry0 <= '{valid: 1'b1, dirty: 1'b0,
                                                          tag: req_tag_q, data: bus.mem_rdata};
                        end
                        mem_req_q <= 1'b0;
                        state_q   <= LOOKUP;
                    end else begin
                        state_q   <= REFILL;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Two-way set-associative, write-back, write-allocate data cache with its own miss-handling FSM.
- Sits between the CPU data port and main memory, with one-word lines.
- Owns tag, data, valid, dirty and LRU state, and sequences lookup, dirty-victim writeback and refill over a req/ack memory handshake.
- Handles one CPU request at a time.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word and line width.
- SETS, 16, number of sets; power of two; SET_BITS = log2(SETS); TAG_BITS = ADDR_WIDTH - SET_BITS - 2.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req_valid  in  1  CPU request; sampled only in IDLE.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_WIDTH  byte address; tag = [31:6], set = [5:2], [1:0] ignored.
- cpu_wdata  in  DATA_WIDTH  store data; full-word writes only.
- cpu_ready  out  1  one-cycle completion strobe.
- cpu_rdata  out  DATA_WIDTH  load data, valid with cpu_ready; 0 for stores.
- hit  out  1  one-cycle pulse on first-lookup hit.
- miss  out  1  one-cycle pulse on first-lookup miss.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  1 = writeback, 0 = refill read.
- mem_addr  out  ADDR_WIDTH  word-aligned line address, bits [1:0] = 0.
- mem_wdata  out  DATA_WIDTH  writeback data.
- mem_rdata  in  DATA_WIDTH  refill data, valid with mem_ack.
- mem_ack  in  1  completes the current request; ignored when mem_req = 0.

Behaviour:
- Reset: state IDLE; all valid, dirty and lru bits cleared; all outputs 0. Reset mid-transaction abandons the transaction with no completion strobe and loses dirty data. Outputs are 0 after the reset edge.
- States: IDLE, LOOKUP, WRITEBACK, REFILL. Outputs are registered.
- IDLE: if cpu_req_valid, register addr, we and wdata, then go to LOOKUP. cpu_req_valid is ignored in every other state.
- LOOKUP: compare the tag against both ways of the set.
  - Hit on a load: cpu_ready = 1, cpu_rdata = way data.
  - Hit on a store: way data = wdata, dirty = 1, cpu_ready = 1.
  - Any hit: lru[set] = the other way; go to IDLE.
  - Hit latency: request accepted at edge N, cpu_ready high in cycle N+1.
- Miss victim selection:
  - First invalid way, preferring way0; otherwise way lru[set].
  - Victim valid and dirty -> WRITEBACK; otherwise -> REFILL.
- WRITEBACK: mem_req = 1, mem_we = 1, mem_addr = {victim tag, set, 2'b00}, mem_wdata = victim data; hold until mem_ack. Then victim dirty = 0 and go to REFILL.
- REFILL: mem_req = 1, mem_we = 0, mem_addr = {req tag, set, 2'b00}; hold until mem_ack.
  - On ack, install mem_rdata in the victim way: valid = 1, dirty = 0, tag = req tag.
  - Then go to LOOKUP; the replay must hit and completes the request as above.
- hit/miss pulses: asserted only on the first LOOKUP of a request, never on the replay. Exactly one of hit or miss pulses per request.
- mem_ack timing: may arrive in the first cycle mem_req is high (zero wait), or after any number of cycles.
  - mem_req drops the cycle after ack when the next state is LOOKUP.
  - WRITEBACK -> REFILL switches mem_we and mem_addr directly, with no idle gap required.
- Storage semantics: arrays hold state across requests; a same-set, different-tag request evicts per LRU.

Decomposition:
- cache_pkg holds:
  - cache_entry_t: packed {valid, dirty, tag[TAG_BITS-1:0], data[DATA_WIDTH-1:0]}.
  - cache_set_t: {entry1, entry0}.
  - cache_state_t enum: IDLE, LOOKUP, WRITEBACK, REFILL.
  - Constants: SET_BITS, TAG_BITS.
- Sub-module cache_way_select (combinational): takes a cache_set_t, tag and lru bit; outputs hit0, hit1, victim way and victim-dirty. Used by the LOOKUP logic and unit-tested alone.

Test Plan:
- Cold load miss: after reset, load 0x40; memory acks after 3 cycles with 0xDEADBEEF -> miss pulse; mem_req read at 0x40; then cpu_ready with rdata 0xDEADBEEF. Reload 0x40 -> hit pulse, cpu_ready 1 cycle after accept, mem_req stays 0.
- Store hit: after the above, store 0x11223344 to 0x40 -> hit, no memory traffic. Load 0x40 -> 0x11223344.
- Dirty eviction (set 0):
  - Load 0x000, store 0xAAAA5555 to 0x040, load 0x000.
  - Then load 0x080 -> WRITEBACK mem_we = 1, addr 0x040, wdata 0xAAAA5555.
  - Then REFILL at 0x080.
  - Finally, load 0x000 hits and load 0x040 misses.
- Clean eviction: same sequence with loads only -> no mem_we = 1 cycle; single refill at 0x080.
- Handshake edges:
  - mem_ack in the same cycle as mem_req rise -> accepted.
  - Spurious mem_ack while idle -> ignored.
  - cpu_req_valid pulsed during REFILL -> ignored, with no second completion.
- Reset mid-REFILL: assert rst while mem_req = 1 -> next cycle mem_req = 0, cpu_ready = 0, no completion strobe. Subsequent load of the same address misses.
